mat_alu_sequencer: RTL and testbench
====================================

Name: mat_alu_sequencer

Overview:
- Bus initiator for the matrix ALU peripheral (peripheral ID 3) on the shared 256-bit bus.
- Accepts one matrix operation request, then runs the bus transaction sequence: write operand A, write operand B, write command, read result.
- Captures the result, returns it to the requester, then releases the bus.
- Sits between the execution unit's op decode and the matrix ALU, replacing hand-sequenced bus cycles.

Parameters:
- PERIPH_ID, 4'd3: value driven on addr[15:12] for all ALU accesses.
- IDLE_ADDR, 16'h0000: addr value when not accessing. Its [15:12] must differ from PERIPH_ID.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- nReset  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  ALU command code 0..7.
- src_a  input  256  operand A (written to ALU reg 0).
- src_b  input  256  operand B or scalar in [31:0] (written to ALU reg 1).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  256  captured ALU result; holds until the next capture.
- addr  output  16  bus address.
- nWrite  output  1  active-low write strobe.
- nRead  output  1  active-low read strobe.
- bus  inout  256  shared data bus; driven only in WR_* states, otherwise 'z.

Behaviour:
- Reset (async, nReset=0): state=IDLE, addr=IDLE_ADDR, nWrite=1, nRead=1, bus released, busy=0, done=0, result=0, latched operands=0.
  - Reset mid-sequence aborts immediately. The bus is released in the same instant.
  - No done is produced for the aborted operation.
- All outputs are registered at posedge. The peripheral samples at negedge, so every strobe and address is stable half a cycle before it is sampled.
- FSM states: IDLE, WR_A, WR_B, WR_CMD, RD_REQ, TURN.
- IDLE, start=1 at posedge:
  - latch op, src_a, src_b
  - go to WR_A; busy=1
  - start in any other state is ignored; no queueing
- WR_A: addr={PERIPH_ID,12'd0}, nWrite=0, bus=A. Next: WR_B.
- WR_B: addr={PERIPH_ID,12'd1}, nWrite=0, bus=B. Next: WR_CMD.
- WR_CMD: addr={PERIPH_ID,12'd3}, nWrite=0, bus={253'b0,op}. Next: RD_REQ.
- RD_REQ: addr={PERIPH_ID,12'd2}, nWrite=1, nRead=0, bus released. The peripheral drives the bus from the following negedge.
  - Next posedge: result<=bus, done=1, go to TURN.
- TURN: addr=IDLE_ADDR, nRead=1, bus released, done=0 at the next edge. The peripheral releases at the negedge when it sees the address mismatch.
  - Next: IDLE, busy=0.
- Timing: done is high in the cycle after the 4th posedge following start sampling. The next start can be accepted 6 posedges after the previous one.
- The master never drives the bus in RD_REQ, TURN or IDLE, so there is no contention at turnaround.
- nWrite and nRead are never both low.
- Operands and op are latched, so changes to src_a, src_b or op after start have no effect on the running sequence.

Optional Feature:
- MAT_SEQ_SKIP_B_EN
- Defined: for op=5 (transpose, B unused), the FSM goes WR_A -> WR_CMD and skips WR_B. ALU reg 1 keeps its old value; start-to-done latency is one cycle shorter.
- Undefined: all ops take the full sequence.

Test Plan:
- Add, A=all elements 16'd2, B=all 16'd3, op=3 -> result all 16'd5.
  - done is a single pulse 4 cycles after start.
  - Bus log shows writes to 0x3000, 0x3001, 0x3003 (data 3), then a read at 0x3002.
- Transpose, A element(i,j)=4i+j, op=5 -> result element(i,j)=4j+i.
  - With MAT_SEQ_SKIP_B_EN defined: no write to 0x3001 and done one cycle earlier.
- Scale, A=all 16'd7, B[31:0]=3, op=6 -> all 16'd21.
  - start pulsed again during busy -> ignored, exactly one done.
  - src_a changed mid-sequence -> result unchanged.
- nReset asserted during RD_REQ -> bus goes Z and strobes go high immediately, no done.
  - Next op (op=4, A=all 9, B=all 4) -> all 16'd5.
- Back-to-back ops, start held high -> second sequence begins at the first IDLE posedge.
  - Bus monitor sees no cycle where the master and ALU both drive the bus.
  - addr returns to 0x0000 between sequences.

Source files
------------

// File: rtl/mat_alu_sequencer.sv
// mat_alu_sequencer: bus initiator for the matrix ALU peripheral.
// It takes one matrix operation request and runs the bus cycles for it:
// write operand A, write operand B, write the command, then read the result.
// It returns the result with a one-cycle done pulse and then releases the bus.
// Optional build macro MAT_SEQ_SKIP_B_EN: when it is defined, transpose (op 5) skips the
// operand B write, because transpose does not use operand B.
module mat_alu_sequencer #(
    parameter logic [3:0]  PERIPH_ID = 4'd3,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [255:0] src_a,
    input  logic [255:0] src_b,
    output logic         busy,
    output logic         done,
    output logic [255:0] result,
    output logic [15:0]  addr,
    output logic         nWrite,
    output logic         nRead,
    inout  wire  [255:0] bus
);

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_B, WR_CMD, RD_REQ, TURN
    } state_t;

    localparam logic [2:0] OP_TRANSPOSE = 3'd5;

    state_t         state;
    logic [2:0]     op_q;
    logic [255:0]   b_q;
    logic           bus_oe;
    logic [255:0]   bus_q;

    // Operand A is loaded straight into the bus output register at start,
    // so only B and the command code need their own latches.
    assign bus = bus_oe ? bus_q : {256{1'bz}};

    // Sequencer FSM. Every output is registered for the state being entered,
    // so addr and the strobes settle half a cycle before the peripheral's negedge sample.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            op_q   <= 3'd0;
            b_q    <= '0;
            bus_q  <= '0;
            bus_oe <= 1'b0;
            addr   <= IDLE_ADDR;
            nWrite <= 1'b1;
            nRead  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        b_q    <= src_b;
                        bus_q  <= src_a;
                        bus_oe <= 1'b1;
                        addr   <= {PERIPH_ID, 12'd0};
                        nWrite <= 1'b0;
                        busy   <= 1'b1;
                        state  <= WR_A;
                    end
                end
                WR_A: begin
`ifdef MAT_SEQ_SKIP_B_EN
                    if (op_q == OP_TRANSPOSE) begin
                        // ALU reg 1 keeps its old contents; transpose ignores it.
                        bus_q <= {253'd0, op_q};
                        addr  <= {PERIPH_ID, 12'd3};
                        state <= WR_CMD;
                    end else begin
                        bus_q <= b_q;
                        addr  <= {PERIPH_ID, 12'd1};
                        state <= WR_B;
                    end
`else
                    bus_q <= b_q;
                    addr  <= {PERIPH_ID, 12'd1};
                    state <= WR_B;
`endif
                end
                WR_B: begin
                    bus_q <= {253'd0, op_q};
                    addr  <= {PERIPH_ID, 12'd3};
                    state <= WR_CMD;
                end
                WR_CMD: begin
                    // Release the bus together with the write strobe. The ALU
                    // starts driving the bus only after it sees nRead at the next negedge.
                    bus_oe <= 1'b0;
                    nWrite <= 1'b1;
                    nRead  <= 1'b0;
                    addr   <= {PERIPH_ID, 12'd2};
                    state  <= RD_REQ;
                end
                RD_REQ: begin
                    result <= bus;
                    done   <= 1'b1;
                    nRead  <= 1'b1;
                    addr   <= IDLE_ADDR;
                    state  <= TURN;
                end
                TURN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    bus_oe <= 1'b0;
                    nWrite <= 1'b1;
                    nRead  <= 1'b1;
                    addr   <= IDLE_ADDR;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_alu_sequencer.sv
// Bench for mat_alu_sequencer. It contains a negedge-sampling matrix ALU peripheral model.
// Expected results are pushed to a scoreboard queue and checked by a separate
// monitor process. The monitor also logs bus cycles and watches for contention.
module tb_mat_alu_sequencer;

    logic         clk = 1'b0;
    logic         nReset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [255:0] src_a = '0;
    logic [255:0] src_b = '0;
    wire          busy, done, nWrite, nRead;
    wire  [255:0] result;
    wire  [15:0]  addr;
    wire  [255:0] bus;

    always #5 clk = ~clk;

    mat_alu_sequencer dut (
        .clk(clk), .nReset(nReset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result(result), .addr(addr), .nWrite(nWrite), .nRead(nRead),
        .bus(bus)
    );

    // Peripheral model (ID 3): 4x4 matrix of 16-bit elements
    logic         alu_oe = 1'b0;
    logic [255:0] alu_data = '0;
    logic [255:0] r0 = '0, r1 = '0;

    assign bus = alu_oe ? alu_data : {256{1'bz}};

    function automatic logic [255:0] alu_f(input logic [2:0] o, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = '0;
        for (int e = 0; e < 16; e++) begin
            case (o)
                3'd3: r[16*e +: 16] = a[16*e +: 16] + b[16*e +: 16];
                3'd4: r[16*e +: 16] = a[16*e +: 16] - b[16*e +: 16];
                3'd5: r[16*e +: 16] = a[16*(4*(e%4) + e/4) +: 16];
                3'd6: r[16*e +: 16] = 16'(a[16*e +: 16] * b[31:0]);
                default: r[16*e +: 16] = a[16*e +: 16];
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (addr[15:12] == 4'd3) begin
            if (!nWrite) begin
                case (addr[11:0])
                    12'd0: r0 <= bus;
                    12'd1: r1 <= bus;
                    12'd3: alu_data <= alu_f(bus[2:0], r0, r1);
                    default: ;
                endcase
            end
            if (!nRead && addr[11:0] == 12'd2) alu_oe <= 1'b1;
        end else begin
            alu_oe <= 1'b0;
        end
    end

    // Scoreboard and logs
    int           n_cmp = 0, n_bad = 0;
    logic [255:0] exp_q[$];
    logic [15:0]  wlog[$];
    logic [255:0] dlog[$];
    logic [15:0]  rlog[$];
    int           done_cyc[$];
    int           ncyc = 0, ndone = 0, contention = 0, strobe_bad = 0;
    logic         done_prev = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            ncyc++;
            if (alu_oe && !nWrite) contention++;
            if (!nWrite && !nRead) strobe_bad++;
            if (!nWrite && addr[15:12] == 4'd3) begin
                wlog.push_back(addr);
                dlog.push_back(bus);
            end
            if (!nRead) rlog.push_back(addr);
            if (done) begin
                ndone++;
                done_cyc.push_back(ncyc);
                chk("done_single_pulse", {255'd0, done_prev}, 256'd0);
                if (exp_q.size() == 0) chk("unexpected_done", 256'd1, 256'd0);
                else chk("result", result, exp_q.pop_front());
            end
            done_prev = done;
        end
    endtask

    // Issue one start and return at the negedge after the sampling posedge
    task automatic start_op(input logic [2:0] o, input logic [255:0] a, input logic [255:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic stim();
        int lat, wb, rb, d0, c0;
        logic [255:0] ta, te;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_result", result, 256'd0);
        chk("rst_addr", {240'd0, addr}, 256'd0);
        chk("rst_nWrite", {255'd0, nWrite}, 256'd1);
        chk("rst_nRead", {255'd0, nRead}, 256'd1);
        nReset = 1'b1;
        @(negedge clk);

        // add: 2 + 3 = 5
        wb = wlog.size(); rb = rlog.size();
        exp_q.push_back({16{16'd5}});
        start_op(3'd3, {16{16'd2}}, {16{16'd3}});
        wait_done(lat);
        chk("add_latency", 256'(lat), 256'd4);
        @(negedge clk);
        chk("add_busy_after", {255'd0, busy}, 256'd0);
        chk("add_wr_count", 256'(wlog.size() - wb), 256'd3);
        chk("add_wr0_addr", {240'd0, wlog[wb]}, 256'h3000);
        chk("add_wr1_addr", {240'd0, wlog[wb+1]}, 256'h3001);
        chk("add_wr2_addr", {240'd0, wlog[wb+2]}, 256'h3003);
        chk("add_cmd_data", dlog[wb+2], 256'd3);
        chk("add_rd_addr", {240'd0, rlog[rb]}, 256'h3002);

        // transpose: element(i,j)=4i+j -> 4j+i
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ta[16*(4*i+j) +: 16] = 16'(4*i + j);
                te[16*(4*i+j) +: 16] = 16'(4*j + i);
            end
        wb = wlog.size();
        exp_q.push_back(te);
        start_op(3'd5, ta, {256{1'b1}});
        wait_done(lat);
`ifdef MAT_SEQ_SKIP_B_EN
        chk("tr_latency", 256'(lat), 256'd3);
        chk("tr_wr_count", 256'(wlog.size() - wb), 256'd2);
`else
        chk("tr_latency", 256'(lat), 256'd4);
        chk("tr_wr_count", 256'(wlog.size() - wb), 256'd3);
`endif
        @(negedge clk);

        // scale 7*3 = 21, with extra start and src_a change mid-sequence
        d0 = ndone;
        exp_q.push_back({16{16'd21}});
        start_op(3'd6, {16{16'd7}}, 256'd3);
        @(negedge clk);
        src_a = {256{1'b1}};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("scale_one_done", 256'(ndone - d0), 256'd1);

        // reset asserted during RD_REQ
        d0 = ndone;
        start_op(3'd3, {16{16'd1}}, {16{16'd1}});
        repeat (3) @(negedge clk);
        chk("abort_in_rdreq", {255'd0, nRead}, 256'd0);
        #2 nReset = 1'b0;
        #1;
        chk("abort_nWrite", {255'd0, nWrite}, 256'd1);
        chk("abort_nRead", {255'd0, nRead}, 256'd1);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_addr", {240'd0, addr}, 256'd0);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 256'(ndone - d0), 256'd0);

        // subtract 9 - 4 = 5
        exp_q.push_back({16{16'd5}});
        start_op(3'd4, {16{16'd9}}, {16{16'd4}});
        wait_done(lat);
        chk("sub_latency", 256'(lat), 256'd4);
        @(negedge clk);

        // back-to-back with start held high
        d0 = ndone; c0 = done_cyc.size();
        exp_q.push_back({16{16'd30}});
        exp_q.push_back({16{16'd20}});
        op = 3'd3; src_a = {16{16'd10}}; src_b = {16{16'd20}}; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = 3'd6; src_a = {16{16'd4}}; src_b = 256'd5;
        repeat (5) @(negedge clk);
        chk("b2b_idle_addr", {240'd0, addr}, 256'd0);
        chk("b2b_idle_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_start", {255'd0, busy}, 256'd1);
        repeat (20) @(negedge clk);
        chk("b2b_two_dones", 256'(ndone - d0), 256'd2);
        chk("b2b_done_spacing", 256'(done_cyc[c0+1] - done_cyc[c0]), 256'd6);

        chk("bus_contention", 256'(contention), 256'd0);
        chk("strobes_both_low", 256'(strobe_bad), 256'd0);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        fork
            monitor();
            stim();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
